// File: rtl/mo_pkg.sv
// Shared types and constants for the motion-object line buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mo_pkg;

  // Horizontal address width; one line holds 2**LINE_XBITS pixels.
  localparam int LINE_XBITS = 8;

  typedef logic [2:0] pix_t;

  // Pixel code meaning "no object here".
  localparam pix_t PIX_TRANSPARENT = 3'b111;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DELAY,
    WR_WRITE
  } wr_state_t;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } top_state_t;

endpackage

// File: rtl/mo_line_ram.sv
// One line bank: 2**AW x 3 RAM, one write port, one read port.
// Latency: read data registered one clk after re; write lands at the clk edge.
// Backpressure: none; read register holds while re is low.
module mo_line_ram
  import mo_pkg::*;
#(
  parameter int   AW      = LINE_XBITS,
  parameter pix_t RST_VAL = PIX_TRANSPARENT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pix_t          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output pix_t          rdata
);

  pix_t mem [2**AW];

  // Storage write; contents are scrubbed by the owner's clear sweep, not by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Synchronous read; reset value keeps stale data off the output after a restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= RST_VAL;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mo_line_buffer.sv
// Ping-pong motion-object line buffer: builds one line while playing back and erasing the other.
// Latency: playback pixel appears one pix_ce tick after its read; first object pixel sampled PIPE_DELAY+1 ticks after load_x.
// Backpressure: none; pixel-rate pacing comes entirely from pix_ce, busy flags the post-reset clear sweep.
module mo_line_buffer
  import mo_pkg::*;
#(
  parameter int   XBITS       = LINE_XBITS,
  parameter int   OBJ_WIDTH   = 8,
  parameter int   PIPE_DELAY  = 2,
  parameter pix_t TRANSPARENT = PIX_TRANSPARENT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_ce,
  input  logic             line_start,
  input  logic             load_x,
  input  logic [XBITS-1:0] obj_x,
  input  logic             flip,
  input  pix_t             ar,
  output pix_t             mo_pix,
  output logic             busy
);

  localparam logic [7:0] PD       = 8'(PIPE_DELAY);
  localparam logic [7:0] LAST_PIX = 8'(OBJ_WIDTH - 1);

  top_state_t       state;
  logic [XBITS-1:0] clr_x;

  wr_state_t        wr_state;
  logic             wr_bank;
  logic [XBITS-1:0] wr_x;
  logic             dir;
  logic [7:0]       dly_cnt;
  logic [7:0]       pix_cnt;

  logic [XBITS-1:0] rd_x;
  logic             rd_sel;

  logic             clearing;
  logic             run_tick;
  logic             wr_go;

  logic             we0, we1, re0, re1;
  logic [XBITS-1:0] waddr0, waddr1;
  pix_t             wdata0, wdata1, rdata0, rdata1;

  assign clearing = (state == ST_CLEAR);
  assign run_tick = (state == ST_RUN) && pix_ce;

  // A pixel is committed only in WRITE, when opaque, and when neither a line
  // boundary nor a fresh load is aborting the current object on this tick.
  assign wr_go = run_tick && (wr_state == WR_WRITE) && !line_start && !load_x &&
                 (ar != TRANSPARENT);

  // Bank 0/1 port steering: clear sweep hits both, otherwise the write bank
  // takes object pixels and the other bank takes the read-behind erase.
  assign we0    = clearing || (wr_bank ? run_tick : wr_go);
  assign we1    = clearing || (wr_bank ? wr_go : run_tick);
  assign waddr0 = clearing ? clr_x : (wr_bank ? rd_x : wr_x);
  assign waddr1 = clearing ? clr_x : (wr_bank ? wr_x : rd_x);
  assign wdata0 = (clearing || wr_bank)  ? TRANSPARENT : ar;
  assign wdata1 = (clearing || !wr_bank) ? TRANSPARENT : ar;
  assign re0    = run_tick && wr_bank;
  assign re1    = run_tick && !wr_bank;

  mo_line_ram #(.AW(XBITS), .RST_VAL(TRANSPARENT)) u_bank0 (
    .clk   (clk),
    .rst   (reset),
    .we    (we0),
    .waddr (waddr0),
    .wdata (wdata0),
    .re    (re0),
    .raddr (rd_x),
    .rdata (rdata0)
  );

  mo_line_ram #(.AW(XBITS), .RST_VAL(TRANSPARENT)) u_bank1 (
    .clk   (clk),
    .rst   (reset),
    .we    (we1),
    .waddr (waddr1),
    .wdata (wdata1),
    .re    (re1),
    .raddr (rd_x),
    .rdata (rdata1)
  );

  // Output is the read register of whichever bank was read on the last tick.
  assign mo_pix = clearing ? TRANSPARENT : (rd_sel ? rdata1 : rdata0);

  // Top sequencer: one clear write per clk across the whole line, then run forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
      clr_x <= '0;
      busy  <= 1'b1;
    end else if (state == ST_CLEAR) begin
      clr_x <= clr_x + XBITS'(1);
      if (clr_x == '1) begin
        state <= ST_RUN;
        busy  <= 1'b0;
      end
    end
  end

  // Playback pointer and bank swap; the line_start tick still performs the last read of the old bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank <= 1'b0;
      rd_x    <= '0;
      rd_sel  <= 1'b0;
    end else if (run_tick) begin
      rd_sel <= ~wr_bank;
      if (line_start) begin
        wr_bank <= ~wr_bank;
        rd_x    <= '0;
      end else begin
        rd_x <= rd_x + XBITS'(1);
      end
    end
  end

  // Object write engine: a load always restarts, a line boundary otherwise aborts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      wr_x     <= '0;
      dir      <= 1'b0;
      dly_cnt  <= '0;
      pix_cnt  <= '0;
    end else if (run_tick) begin
      if (load_x) begin
        wr_x     <= obj_x;
        dir      <= flip;
        dly_cnt  <= PD;
        pix_cnt  <= '0;
        wr_state <= (PD == 8'd0) ? WR_WRITE : WR_DELAY;
      end else if (line_start) begin
        wr_state <= WR_IDLE;
      end else begin
        case (wr_state)
          WR_DELAY: begin
            dly_cnt <= dly_cnt - 8'd1;
            if (dly_cnt <= 8'd1) begin
              wr_state <= WR_WRITE;
            end
          end
          WR_WRITE: begin
            wr_x    <= dir ? (wr_x - XBITS'(1)) : (wr_x + XBITS'(1));
            pix_cnt <= pix_cnt + 8'd1;
            if (pix_cnt == LAST_PIX) begin
              wr_state <= WR_IDLE;
            end
          end
          default: wr_state <= WR_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mo_line_buffer.sv
// Directed bench for mo_line_buffer with a playback scoreboard.
// Latency: expected pixel pushed when a tick is driven, popped one tick later.
// Backpressure: n/a.
module tb_mo_line_buffer;
  import mo_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic       line_start;
  logic       load_x;
  logic [7:0] obj_x;
  logic       flip;
  pix_t       ar;
  pix_t       mo_pix;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  pix_t exp_play [256];
  pix_t exp_next [256];
  bit   ld_v     [256];
  logic [7:0] ld_x [256];
  bit   ld_f     [256];
  pix_t ar_s     [256];
  pix_t exp_q    [$];

  mo_line_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .line_start (line_start),
    .load_x     (load_x),
    .obj_x      (obj_x),
    .flip       (flip),
    .ar         (ar),
    .mo_pix     (mo_pix),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 256; i++) begin
      ld_v[i] = 1'b0;
      ld_x[i] = 8'h00;
      ld_f[i] = 1'b0;
      ar_s[i] = 3'b111;
    end
  endtask

  task automatic next_line();
    for (int i = 0; i < 256; i++) begin
      exp_play[i] = exp_next[i];
      exp_next[i] = 3'b111;
    end
  endtask

  // Place an object: load on tick t0, pixels sampled from tick t0+3.
  task automatic sched_obj(input int t0, input logic [7:0] x, input bit f, input pix_t p [8]);
    ld_v[t0] = 1'b1;
    ld_x[t0] = x;
    ld_f[t0] = f;
    for (int i = 0; i < 8; i++) begin
      if (t0 + 3 + i < 256) ar_s[t0 + 3 + i] = p[i];
    end
  endtask

  // Wait out the clear sweep from reset release, counting clks while busy.
  task automatic measure_clear();
    int cnt;
    cnt = 0;
    chk("busy_at_release", {31'd0, busy}, 32'd1);
    while (busy === 1'b1 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      chk("clear_mo_pix", {29'd0, mo_pix}, 32'd7);
    end
    chk("clear_length", cnt, 256);
    chk("busy_after_clear", {31'd0, busy}, 32'd0);
  endtask

  // Drive n pixel ticks (one every 2 clks); tick 255 carries line_start.
  task automatic run_line(input int n);
    pix_t e;
    pix_t last_e;
    last_e = 3'b111;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (t % 64 == 1) chk("hold", {29'd0, mo_pix}, {29'd0, last_e});
      pix_ce     = 1'b1;
      line_start = (t == 255);
      load_x     = ld_v[t];
      obj_x      = ld_x[t];
      flip       = ld_f[t];
      ar         = ar_s[t];
      exp_q.push_back(exp_play[t]);
      @(negedge clk);
      pix_ce     = 1'b0;
      line_start = 1'b0;
      load_x     = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("pix x=%02h", t), {29'd0, mo_pix}, {29'd0, e});
      last_e = e;
    end
  endtask

  initial begin
    pix_t p [8];
    reset = 1'b1; pix_ce = 1'b0; line_start = 1'b0; load_x = 1'b0;
    obj_x = 8'h00; flip = 1'b0; ar = 3'b111;
    for (int i = 0; i < 256; i++) begin
      exp_play[i] = 3'b111;
      exp_next[i] = 3'b111;
    end
    clear_sched();
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_mo_pix", {29'd0, mo_pix}, 32'd7);
    reset = 1'b0;
    measure_clear();

    // L1, L2: idle lines read all transparent.
    run_line(256); next_line();
    run_line(256); next_line();

    // L3: object at 0x10, rightwards, with one opaque zero pixel.
    clear_sched();
    p = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
    sched_obj(20, 8'h10, 1'b0, p);
    ar_s[21] = 3'd4; ar_s[22] = 3'd4; ar_s[31] = 3'd4;
    for (int i = 0; i < 8; i++) exp_next[8'h10 + i] = p[i];
    run_line(256); next_line();

    // L4: play L3; build flipped object wrapping through 0.
    clear_sched();
    p = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    sched_obj(40, 8'h02, 1'b1, p);
    exp_next[8'h02] = 3'd1; exp_next[8'h01] = 3'd1; exp_next[8'h00] = 3'd1;
    exp_next[8'hFF] = 3'd1; exp_next[8'hFE] = 3'd1; exp_next[8'hFD] = 3'd1;
    exp_next[8'hFC] = 3'd1; exp_next[8'hFB] = 3'd1;
    run_line(256); next_line();

    // L5: play flip; build overlapping A then B into the bank L3 used.
    clear_sched();
    p = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    sched_obj(10, 8'h40, 1'b0, p);
    p = '{3'd7, 3'd7, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7, 3'd7};
    sched_obj(30, 8'h44, 1'b0, p);
    for (int i = 0; i < 6; i++) exp_next[8'h40 + i] = 3'd2;
    exp_next[8'h46] = 3'd5; exp_next[8'h47] = 3'd5;
    run_line(256); next_line();

    // L6: play priority; object at 0x80 cut off by line_start after 3 pixels,
    // plus a new load coincident with line_start.
    clear_sched();
    p = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
    sched_obj(249, 8'h80, 1'b0, p);
    ld_v[255] = 1'b1; ld_x[255] = 8'h20; ld_f[255] = 1'b0;
    exp_next[8'h80] = 3'd3; exp_next[8'h81] = 3'd3; exp_next[8'h82] = 3'd3;
    run_line(256); next_line();

    // L7: play abort; coincident load pixels land in the new bank.
    clear_sched();
    ar_s[0] = 3'd3; ar_s[1] = 3'd3; ar_s[10] = 3'd3;
    for (int i = 2; i < 10; i++) ar_s[i] = 3'd4;
    for (int i = 0; i < 8; i++) exp_next[8'h20 + i] = 3'd4;
    run_line(256); next_line();

    // L8: play 0x20 object; reset while another object is mid-write.
    clear_sched();
    p = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
    sched_obj(100, 8'h60, 1'b0, p);
    run_line(106);
    chk("run_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy", {31'd0, busy}, 32'd1);
    chk("midrun_reset_mo_pix", {29'd0, mo_pix}, 32'd7);
    @(negedge clk);
    reset = 1'b0;
    measure_clear();

    // L9, L10: nothing survives the clear in either bank.
    clear_sched();
    for (int i = 0; i < 256; i++) begin
      exp_play[i] = 3'b111;
      exp_next[i] = 3'b111;
    end
    run_line(256); next_line();
    run_line(256); next_line();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
